// File: rtl/fp16_pkg.sv
// fp16_pkg: shared FP16 widths, bias and divider state encoding
package fp16_pkg;
  localparam int FP16_MANT_W   = 11;
  localparam int FP16_EXP_W    = 5;
  localparam int FP16_EXP_BIAS = 15;
  typedef enum logic [1:0] {IDLE, CALC, DONE} div_state_t;
endpackage

// File: rtl/fp16_div_step.sv
// fp16_div_step: one restoring-division iteration (compare, subtract, shift)
module fp16_div_step #(
  parameter int W = 11
) (
  input  logic [W:0]   i_rem,
  input  logic [W-1:0] i_div,
  output logic [W:0]   o_rem,
  output logic         o_q
);
  logic [W:0] w_diff;
  assign o_q    = i_rem >= {1'b0, i_div};
  assign w_diff = i_rem - {1'b0, i_div};
  assign o_rem  = (o_q ? w_diff : i_rem) << 1;
endmodule

// File: rtl/fp16_div_seq.sv
// fp16_div_seq: sequential FP16 mantissa/exponent divider, one quotient bit per clock
module fp16_div_seq
  import fp16_pkg::*;
#(
  parameter int MANT_W   = FP16_MANT_W,
  parameter int EXP_W    = FP16_EXP_W,
  parameter int EXP_BIAS = FP16_EXP_BIAS,
  parameter int QUOT_W   = MANT_W + 1
) (
  input  logic              clk_alu,
  input  logic              rst_alu,
  input  logic              start,
  input  logic [MANT_W-1:0] operand_a_mant,
  input  logic [MANT_W-1:0] operand_b_mant,
  input  logic [EXP_W-1:0]  operand_a_exp,
  input  logic [EXP_W-1:0]  operand_b_exp,
  input  logic              operand_a_sign,
  input  logic              operand_b_sign,
  output logic              busy,
  output logic              done,
  output logic [QUOT_W-1:0] result_mant,
  output logic [EXP_W+1:0]  result_exp,
  output logic              result_sign,
  output logic              result_sticky,
  output logic              div_by_zero
);
  localparam int CNT_W = $clog2(QUOT_W);
  div_state_t        r_state;
  logic [MANT_W:0]   r_rem, w_rem_nxt, w_rem_load;
  logic [MANT_W-1:0] r_div;
  logic [CNT_W-1:0]  r_cnt;
  logic [QUOT_W-1:0] r_quot, w_quot_nxt;
  logic [EXP_W+1:0]  w_exp;
  logic              w_q, w_accept, w_zero;

  // Only quotient bits below 2^QUOT_W are kept, so multiples of 2*d in the
  // dividend can be discarded up front; this keeps r < 2*d for unnormalized divisors.
  function automatic logic [MANT_W:0] f_mod2d(input logic [MANT_W-1:0] a, input logic [MANT_W-1:0] d);
    logic [MANT_W:0]   r;
    logic [2*MANT_W:0] m;
    r = {1'b0, a};
    for (int k = MANT_W - 1; k >= 0; k--) begin
      m = (2*MANT_W+1)'({d, 1'b0}) << k;
      if ((2*MANT_W+1)'(r) >= m) r = r - m[MANT_W:0];
    end
    return r;
  endfunction

  assign w_accept   = start && r_state != CALC;
  assign w_zero     = operand_b_mant == '0;
  assign w_exp      = (EXP_W+2)'(operand_a_exp) - (EXP_W+2)'(operand_b_exp) + (EXP_W+2)'(EXP_BIAS);
  assign w_quot_nxt = r_quot | (QUOT_W'(w_q) << r_cnt);
  assign w_rem_load = f_mod2d(operand_a_mant, operand_b_mant);

  fp16_div_step #(.W(MANT_W)) u_step (
    .i_rem(r_rem),
    .i_div(r_div),
    .o_rem(w_rem_nxt),
    .o_q  (w_q)
  );

  always_ff @(posedge clk_alu) begin
    if (rst_alu) begin
      r_state       <= IDLE;
      r_rem         <= '0;
      r_div         <= '0;
      r_cnt         <= '0;
      r_quot        <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      result_mant   <= '0;
      result_exp    <= '0;
      result_sign   <= 1'b0;
      result_sticky <= 1'b0;
      div_by_zero   <= 1'b0;
    end else if (w_accept) begin
      result_sign <= operand_a_sign ^ operand_b_sign;
      result_exp  <= w_exp;
      r_state     <= w_zero ? DONE : CALC;
      busy        <= !w_zero;
      done        <= w_zero;
      r_rem       <= w_rem_load;
      r_div       <= operand_b_mant;
      r_cnt       <= CNT_W'(QUOT_W - 1);
      r_quot      <= '0;
      if (w_zero) begin
        result_mant   <= '1;
        result_sticky <= 1'b0;
        div_by_zero   <= 1'b1;
      end
    end else if (r_state == CALC) begin
      r_rem  <= w_rem_nxt;
      r_quot <= w_quot_nxt;
      r_cnt  <= r_cnt - 1'b1;
      if (r_cnt == '0) begin
        r_state       <= DONE;
        busy          <= 1'b0;
        done          <= 1'b1;
        result_mant   <= w_quot_nxt;
        result_sticky <= |w_rem_nxt;
        div_by_zero   <= 1'b0;
      end
    end else begin
      r_state <= IDLE;
      done    <= 1'b0;
    end
  end
endmodule

// File: tb/tb_fp16_div_seq.sv
// tb_fp16_div_seq: directed vectors with a scoreboard queue checked on every done pulse
module tb_fp16_div_seq;
  logic        clk_alu = 1'b0, rst_alu = 1'b1, start = 1'b0;
  logic [10:0] a_m = '0, b_m = '0;
  logic [4:0]  a_e = '0, b_e = '0;
  logic        a_s = 1'b0, b_s = 1'b0;
  logic        busy, done, result_sign, result_sticky, div_by_zero;
  logic [11:0] result_mant;
  logic [6:0]  result_exp;

  typedef struct packed {
    logic [11:0] m;
    logic [6:0]  e;
    logic        s;
    logic        st;
    logic        z;
  } res_t;

  res_t q[$];
  int checks = 0, failures = 0;

  fp16_div_seq dut (
    .clk_alu(clk_alu), .rst_alu(rst_alu), .start(start),
    .operand_a_mant(a_m), .operand_b_mant(b_m),
    .operand_a_exp(a_e), .operand_b_exp(b_e),
    .operand_a_sign(a_s), .operand_b_sign(b_s),
    .busy(busy), .done(done), .result_mant(result_mant), .result_exp(result_exp),
    .result_sign(result_sign), .result_sticky(result_sticky), .div_by_zero(div_by_zero)
  );

  always #5 clk_alu = ~clk_alu;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", n, act, exp);
    end
  endtask

  function automatic res_t mk(input logic [11:0] m, input logic [6:0] e, input logic s, input logic st, input logic z);
    return {m, e, s, st, z};
  endfunction

  always @(negedge clk_alu) begin
    res_t e;
    if (done === 1'b1) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done actual=1 expected=0");
      end else begin
        e = q.pop_front();
        chk("result{mant,exp,sign,sticky,dbz}",
            32'({result_mant, result_exp, result_sign, result_sticky, div_by_zero}), 32'(e));
      end
    end
  end

  task automatic wait_done(output int cnt);
    cnt = 1;
    while (done !== 1'b1 && cnt < 40) begin
      @(posedge clk_alu);
      #1;
      cnt++;
    end
  endtask

  task automatic op(input logic [10:0] am, input logic [4:0] ae, input logic as_,
                    input logic [10:0] bm, input logic [4:0] be, input logic bs,
                    input res_t r, input int lat, input string n);
    int cnt;
    @(negedge clk_alu);
    a_m = am; a_e = ae; a_s = as_; b_m = bm; b_e = be; b_s = bs;
    start = 1'b1;
    q.push_back(r);
    @(posedge clk_alu);
    #1 start = 1'b0;
    chk({n, "_busy"}, 32'(busy), 32'(lat != 1));
    wait_done(cnt);
    chk({n, "_latency"}, cnt, lat);
  endtask

  initial begin
    int cnt, dcnt;
    repeat (3) @(posedge clk_alu);
    #1 chk("reset_outputs", 32'({busy, done, result_mant, result_exp, result_sign, result_sticky, div_by_zero}), 0);
    @(negedge clk_alu) rst_alu = 1'b0;

    op(1024, 15, 0, 1024, 15, 0, mk(2048, 15, 0, 0, 0), 13, "one");
    @(posedge clk_alu);
    #1 chk("one_done_pulse", 32'(done), 0);
    op(2047, 15, 1, 1024, 15, 0, mk(4094, 15, 1, 0, 0), 13, "max");
    op(1024, 15, 0, 2047, 15, 0, mk(1024, 15, 0, 1, 0), 13, "min");
    op(1024, 0, 0, 1024, 31, 0, mk(2048, 7'h70, 0, 0, 0), 13, "exp_min");
    op(1024, 31, 0, 1024, 0, 0, mk(2048, 7'd46, 0, 0, 0), 13, "exp_max");
    op(1536, 20, 0, 0, 10, 1, mk(12'hFFF, 7'd25, 1, 0, 1), 1, "dbz");
    op(1536, 15, 0, 0, 15, 0, mk(12'hFFF, 7'd15, 0, 0, 1), 1, "dbz_again");
    op(1536, 15, 0, 1280, 15, 0, mk(2457, 15, 0, 1, 0), 13, "frac");
    op(0, 15, 0, 1024, 15, 0, mk(0, 15, 0, 0, 0), 13, "zero_dividend");
    op(2047, 15, 0, 3, 15, 0, mk(682, 15, 0, 1, 0), 13, "unnorm");

    // start held high: operands changed mid-CALC are ignored, then re-accepted in DONE
    @(negedge clk_alu);
    a_m = 1024; a_e = 15; a_s = 0; b_m = 1024; b_e = 15; b_s = 0;
    start = 1'b1;
    q.push_back(mk(2048, 15, 0, 0, 0));
    q.push_back(mk(2457, 15, 0, 1, 0));
    @(posedge clk_alu);
    #1 a_m = 1536; b_m = 1280;
    wait_done(cnt);
    chk("hold_latency", cnt, 13);
    @(posedge clk_alu);
    #1 start = 1'b0;
    chk("b2b_busy", 32'(busy), 1);
    wait_done(cnt);
    chk("b2b_latency", cnt, 13);

    @(negedge clk_alu);
    a_m = 1024; b_m = 2047; a_s = 1; a_e = 3;
    start = 1'b1;
    @(posedge clk_alu);
    #1 start = 1'b0;
    repeat (5) @(posedge clk_alu);
    @(negedge clk_alu) rst_alu = 1'b1;
    @(posedge clk_alu);
    #1 chk("midop_reset_outputs", 32'({busy, done, result_mant, result_exp, result_sign, result_sticky, div_by_zero}), 0);
    @(negedge clk_alu) rst_alu = 1'b0;
    dcnt = 0;
    repeat (20) begin
      @(posedge clk_alu);
      #1 if (done === 1'b1) dcnt++;
    end
    chk("midop_reset_no_done", dcnt, 0);
    op(1536, 15, 0, 1024, 15, 0, mk(3072, 15, 0, 0, 0), 13, "after_reset");

    repeat (3) @(posedge clk_alu);
    #1 chk("scoreboard_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
